// File: rtl/mips_v2_top.sv
// mips_v2_top: single-cycle MIPS-subset datapath (32x32 register file, decoder, ALU).
// The instruction arrives on INST each cycle; there is no instruction memory or PC.
// Optional shift instructions are compiled in when the MIPS_SHIFT_EN macro is defined.
//
// Ports:
//   CLK   in   1   clock, all state updates on the rising edge
//   RST   in   1   synchronous active-high reset (registers and outputs cleared)
//   write in   1   register-file write enable for the current instruction
//   INST  in   32  MIPS instruction word
//   flag  out  1   registered ALU zero flag
//   out   out  32  registered ALU result
//   ina   out  32  registered rs read data
//   inb   out  32  registered rt read data
//   ALUA  out  32  registered ALU operand A
//   ALUB  out  32  registered ALU operand B
//   addr  out  5   registered destination register index
module mips_v2_top (
   input  logic        CLK,
   input  logic        RST,
   input  logic        write,
   input  logic [31:0] INST,
   output logic        flag,
   output logic [31:0] out,
   output logic [31:0] ina,
   output logic [31:0] inb,
   output logic [31:0] ALUA,
   output logic [31:0] ALUB,
   output logic [4:0]  addr
);

   localparam int unsigned DW   = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;

   logic [DW-1:0] rf_q [NREG];
   logic [DW-1:0] rf_d [NREG];

   logic          flag_q, flag_d;
   logic [DW-1:0] out_q,  out_d;
   logic [DW-1:0] ina_q,  ina_d;
   logic [DW-1:0] inb_q,  inb_d;
   logic [DW-1:0] alua_q, alua_d;
   logic [DW-1:0] alub_q, alub_d;
   logic [AW-1:0] addr_q, addr_d;

   logic [5:0]    op;
   logic [5:0]    funct;
   logic [AW-1:0] rs, rt, rd;
   logic [15:0]   imm;
   logic [DW-1:0] sext_imm, zext_imm;
   logic          valid;
   logic          wb_ok;
   logic          we;

   // Field extraction and combinational register reads (r0 hard-wired to zero)
   always_comb begin
      op       = INST[31:26];
      rs       = INST[25:21];
      rt       = INST[20:16];
      rd       = INST[15:11];
      funct    = INST[5:0];
      imm      = INST[15:0];
      sext_imm = {{16{imm[15]}}, imm};
      zext_imm = {16'h0000, imm};
      ina_d    = (rs == AW'(0)) ? '0 : rf_q[rs];
      inb_d    = (rt == AW'(0)) ? '0 : rf_q[rt];
   end

   // Decode, operand selection and ALU
   always_comb begin
      alua_d = ina_d;
      alub_d = inb_d;
      out_d  = '0;
      addr_d = '0;
      valid  = 1'b0;
      wb_ok  = 1'b1;
      case (op)
         6'h00: begin
            addr_d = rd;
            valid  = 1'b1;
            case (funct)
               6'h20, 6'h21: out_d = alua_d + alub_d;
               6'h22, 6'h23: out_d = alua_d - alub_d;
               6'h24:        out_d = alua_d & alub_d;
               6'h25:        out_d = alua_d | alub_d;
               6'h26:        out_d = alua_d ^ alub_d;
               6'h27:        out_d = ~(alua_d | alub_d);
               6'h2A:        out_d = ($signed(alua_d) < $signed(alub_d)) ? DW'(1) : DW'(0);
               6'h2B:        out_d = (alua_d < alub_d) ? DW'(1) : DW'(0);
               6'h0A: begin
                  // movz: pass rs through, commit only when rt reads zero
                  out_d = alua_d;
                  wb_ok = (inb_d == '0);
               end
`ifdef MIPS_SHIFT_EN
               6'h00, 6'h02, 6'h03: begin
                  alua_d = inb_d;
                  alub_d = {27'h0, INST[10:6]};
                  if (funct == 6'h00)      out_d = alua_d << alub_d[4:0];
                  else if (funct == 6'h02) out_d = alua_d >> alub_d[4:0];
                  else                     out_d = DW'($signed(alua_d) >>> alub_d[4:0]);
               end
               6'h04, 6'h06, 6'h07: begin
                  alua_d = inb_d;
                  alub_d = ina_d;
                  if (funct == 6'h04)      out_d = alua_d << alub_d[4:0];
                  else if (funct == 6'h06) out_d = alua_d >> alub_d[4:0];
                  else                     out_d = DW'($signed(alua_d) >>> alub_d[4:0]);
               end
`endif
               default: valid = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin
            addr_d = rt; valid = 1'b1; alub_d = sext_imm;
            out_d  = alua_d + alub_d;
         end
         6'h0A: begin
            addr_d = rt; valid = 1'b1; alub_d = sext_imm;
            out_d  = ($signed(alua_d) < $signed(alub_d)) ? DW'(1) : DW'(0);
         end
         6'h0C: begin
            addr_d = rt; valid = 1'b1; alub_d = zext_imm;
            out_d  = alua_d & alub_d;
         end
         6'h0D: begin
            addr_d = rt; valid = 1'b1; alub_d = zext_imm;
            out_d  = alua_d | alub_d;
         end
         6'h0E: begin
            addr_d = rt; valid = 1'b1; alub_d = zext_imm;
            out_d  = alua_d ^ alub_d;
         end
         6'h0F: begin
            addr_d = rt; valid = 1'b1; alub_d = zext_imm;
            out_d  = {imm, 16'h0000};
         end
         default: valid = 1'b0;
      endcase
      // Undefined encodings report a null result and destination
      if (!valid) begin
         out_d  = '0;
         addr_d = '0;
      end
      flag_d = (out_d == '0);
   end

   // Register-file next state; writes to r0 are dropped
   always_comb begin
      we = write & valid & wb_ok & ~RST;
      for (int i = 0; i < int'(NREG); i++) rf_d[i] = rf_q[i];
      if (we && (addr_d != AW'(0))) rf_d[addr_d] = out_d;
   end

   // State and monitor registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
         flag_q <= 1'b0;
         out_q  <= '0;
         ina_q  <= '0;
         inb_q  <= '0;
         alua_q <= '0;
         alub_q <= '0;
         addr_q <= '0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= rf_d[i];
         flag_q <= flag_d;
         out_q  <= out_d;
         ina_q  <= ina_d;
         inb_q  <= inb_d;
         alua_q <= alua_d;
         alub_q <= alub_d;
         addr_q <= addr_d;
      end
   end

   assign flag = flag_q;
   assign out  = out_q;
   assign ina  = ina_q;
   assign inb  = inb_q;
   assign ALUA = alua_q;
   assign ALUB = alub_q;
   assign addr = addr_q;

endmodule

// File: tb/tb_mips_v2_top.sv
// tb_mips_v2_top: directed self-checking bench for mips_v2_top.
// Each task applies an instruction sequence and compares the registered monitor
// ports against hand-computed values one clock after the instruction is applied.
module tb_mips_v2_top;

   logic        CLK = 1'b0;
   logic        RST;
   logic        write;
   logic [31:0] INST;
   logic        flag;
   logic [31:0] out, ina, inb, ALUA, ALUB;
   logic [4:0]  addr;

   int n_tests = 0;
   int n_fail  = 0;

   mips_v2_top dut (
      .CLK(CLK), .RST(RST), .write(write), .INST(INST),
      .flag(flag), .out(out), .ina(ina), .inb(inb),
      .ALUA(ALUA), .ALUB(ALUB), .addr(addr)
   );

   always #5 CLK = ~CLK;

   // Apply current inputs across one rising edge, then sample 1ns later
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; write = 1'b1; INST = 32'h20080005;
      step();
      n_tests++;
      if ({flag, out, ina, inb, ALUA, ALUB, addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: flag=%0b out=%h ina=%h inb=%h ALUA=%h ALUB=%h addr=%0d, want all 0",
                  flag, out, ina, inb, ALUA, ALUB, addr);
      end
      RST = 1'b0; INST = 32'h0000000A;
      for (int c = 0; c < 50; c++) begin
         step();
         n_tests++;
         if (out !== 32'h0 || flag !== 1'b1 || addr !== 5'd0 || ina !== 32'h0 || inb !== 32'h0) begin
            n_fail++;
            $display("FAIL movz_r0 cycle %0d: out=%h flag=%0b addr=%0d ina=%h inb=%h, want 0/1/0/0/0",
                     c, out, flag, addr, ina, inb);
         end
      end
   endtask

   task automatic test_addi_add();
      write = 1'b1; INST = 32'h20080005;             // addi $8,$0,5
      step();
      n_tests++;
      if (out !== 32'd5 || addr !== 5'd8 || ALUB !== 32'd5 || ALUA !== 32'd0 || flag !== 1'b0) begin
         n_fail++;
         $display("FAIL addi: out=%h addr=%0d ALUA=%h ALUB=%h flag=%0b, want 5/8/0/5/0", out, addr, ALUA, ALUB, flag);
      end
      INST = 32'h01084820;                           // add $9,$8,$8
      step();
      n_tests++;
      if (ina !== 32'd5 || inb !== 32'd5 || out !== 32'd10 || addr !== 5'd9 || flag !== 1'b0) begin
         n_fail++;
         $display("FAIL add: ina=%h inb=%h out=%h addr=%0d flag=%0b, want 5/5/a/9/0", ina, inb, out, addr, flag);
      end
   endtask

   task automatic test_sub_write_gate();
      write = 1'b1; INST = 32'h01085022;             // sub $10,$8,$8
      step();
      n_tests++;
      if (out !== 32'd0 || flag !== 1'b1 || addr !== 5'd10) begin
         n_fail++;
         $display("FAIL sub_zero: out=%h flag=%0b addr=%0d, want 0/1/10", out, flag, addr);
      end
      write = 1'b0; INST = 32'h20080007;             // addi $8,$0,7 without write
      step();
      n_tests++;
      if (out !== 32'd7 || addr !== 5'd8 || flag !== 1'b0) begin
         n_fail++;
         $display("FAIL addi_nowrite: out=%h addr=%0d flag=%0b, want 7/8/0", out, addr, flag);
      end
      write = 1'b1; INST = 32'h01084820;             // add $9,$8,$8
      step();
      n_tests++;
      if (ina !== 32'd5 || out !== 32'd10) begin
         n_fail++;
         $display("FAIL write_gate: ina=%h out=%h, want 5/a", ina, out);
      end
   endtask

   task automatic test_slt_lui_ori();
      write = 1'b1; INST = 32'h3C0C8000;             // lui $12,0x8000
      step();
      n_tests++;
      if (out !== 32'h80000000 || addr !== 5'd12 || ALUB !== 32'h00008000) begin
         n_fail++;
         $display("FAIL lui: out=%h addr=%0d ALUB=%h, want 80000000/12/00008000", out, addr, ALUB);
      end
      INST = 32'h0188682A;                           // slt $13,$12,$8
      step();
      n_tests++;
      if (out !== 32'd1 || ina !== 32'h80000000 || inb !== 32'd5 || addr !== 5'd13 || flag !== 1'b0) begin
         n_fail++;
         $display("FAIL slt: out=%h ina=%h inb=%h addr=%0d flag=%0b, want 1/80000000/5/13/0", out, ina, inb, addr, flag);
      end
      INST = 32'h0188682B;                           // sltu $13,$12,$8
      step();
      n_tests++;
      if (out !== 32'd0 || flag !== 1'b1) begin
         n_fail++;
         $display("FAIL sltu: out=%h flag=%0b, want 0/1", out, flag);
      end
      INST = 32'h340EFFFF;                           // ori $14,$0,0xFFFF
      step();
      n_tests++;
      if (out !== 32'h0000FFFF || ALUB !== 32'h0000FFFF || addr !== 5'd14) begin
         n_fail++;
         $display("FAIL ori: out=%h ALUB=%h addr=%0d, want 0000ffff/0000ffff/14", out, ALUB, addr);
      end
   endtask

   task automatic test_misc_alu();
      write = 1'b1; INST = 32'h00089022;             // sub $18,$0,$8 -> wraps
      step();
      n_tests++;
      if (out !== 32'hFFFFFFFB || addr !== 5'd18) begin
         n_fail++;
         $display("FAIL sub_wrap: out=%h addr=%0d, want fffffffb/18", out, addr);
      end
      INST = 32'h00009827;                           // nor $19,$0,$0
      step();
      n_tests++;
      if (out !== 32'hFFFFFFFF || flag !== 1'b0) begin
         n_fail++;
         $display("FAIL nor: out=%h flag=%0b, want ffffffff/0", out, flag);
      end
      INST = 32'h2114FFFF;                           // addi $20,$8,-1
      step();
      n_tests++;
      if (out !== 32'd4 || ALUB !== 32'hFFFFFFFF || addr !== 5'd20) begin
         n_fail++;
         $display("FAIL addi_neg: out=%h ALUB=%h addr=%0d, want 4/ffffffff/20", out, ALUB, addr);
      end
      INST = 32'hFC000000;                           // undefined opcode
      step();
      n_tests++;
      if (out !== 32'd0 || addr !== 5'd0 || flag !== 1'b1) begin
         n_fail++;
         $display("FAIL undef_op: out=%h addr=%0d flag=%0b, want 0/0/1", out, addr, flag);
      end
   endtask

   task automatic test_movz();
      write = 1'b1; INST = 32'h0100780A;             // movz $15,$8,$0 -> writes
      step();
      n_tests++;
      if (out !== 32'd5 || addr !== 5'd15) begin
         n_fail++;
         $display("FAIL movz_take: out=%h addr=%0d, want 5/15", out, addr);
      end
      INST = 32'h0108800A;                           // movz $16,$8,$8 -> blocked
      step();
      n_tests++;
      if (out !== 32'd5 || addr !== 5'd16) begin
         n_fail++;
         $display("FAIL movz_block: out=%h addr=%0d, want 5/16", out, addr);
      end
      INST = 32'h01F08820;                           // add $17,$15,$16
      step();
      n_tests++;
      if (ina !== 32'd5 || inb !== 32'd0 || out !== 32'd5) begin
         n_fail++;
         $display("FAIL movz_effect: ina=%h inb=%h out=%h, want 5/0/5", ina, inb, out);
      end
   endtask

   task automatic test_shift();
      write = 1'b1; INST = 32'h00085880;             // sll $11,$8,2
      step();
      n_tests++;
`ifdef MIPS_SHIFT_EN
      if (ALUA !== 32'd5 || ALUB !== 32'd2 || out !== 32'd20 || addr !== 5'd11) begin
         n_fail++;
         $display("FAIL sll: ALUA=%h ALUB=%h out=%h addr=%0d, want 5/2/14/11", ALUA, ALUB, out, addr);
      end
`else
      if (out !== 32'd0 || addr !== 5'd0 || flag !== 1'b1) begin
         n_fail++;
         $display("FAIL sll_disabled: out=%h addr=%0d flag=%0b, want 0/0/1", out, addr, flag);
      end
`endif
      INST = 32'h0160A820;                           // add $21,$11,$0
      step();
      n_tests++;
`ifdef MIPS_SHIFT_EN
      if (ina !== 32'd20) begin
         n_fail++;
         $display("FAIL sll_wb: ina=%h, want 14", ina);
      end
`else
      if (ina !== 32'd0) begin
         n_fail++;
         $display("FAIL sll_no_wb: ina=%h, want 0", ina);
      end
`endif
   endtask

   task automatic test_reset_mid();
      RST = 1'b1; write = 1'b1; INST = 32'h20080007; // addi pending under reset
      step();
      n_tests++;
      if ({flag, out, ina, inb, ALUA, ALUB, addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: flag=%0b out=%h ina=%h inb=%h ALUA=%h ALUB=%h addr=%0d, want all 0",
                  flag, out, ina, inb, ALUA, ALUB, addr);
      end
      RST = 1'b0; INST = 32'h01084820;               // add $9,$8,$8
      step();
      n_tests++;
      if (out !== 32'd0 || ina !== 32'd0 || flag !== 1'b1 || addr !== 5'd9) begin
         n_fail++;
         $display("FAIL after_reset: out=%h ina=%h flag=%0b addr=%0d, want 0/0/1/9", out, ina, flag, addr);
      end
   endtask

   initial begin
      RST = 1'b1; write = 1'b0; INST = 32'h0;
      test_reset();
      test_addi_add();
      test_sub_write_gate();
      test_slt_lui_ori();
      test_misc_alu();
      test_movz();
      test_shift();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
